// File: rtl/conv_pkg.sv
// Shared definitions for the convolution scheduler: FSM encoding and the
// per-row accumulator width rule.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } conv_state_e;

    // A K-term sum of DATA_WIDTH x DATA_WIDTH products needs 2*DATA_WIDTH bits plus growth headroom.
    function automatic int sum_width(input int kernel, input int data_w);
        return data_w * 2 + kernel;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO buffering PE-array results
// until the downstream consumer accepts them.
module result_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/conv_scheduler.sv
// Job scheduler for a KxK convolution PE array: loads weights, streams pixel
// columns under result-FIFO credit, and buffers row sums for the consumer.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int SUM_WIDTH   = sum_width(KERNEL_SIZE, DATA_WIDTH),
    parameter int ADDR_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]                     cfg_in_base,
    input  logic [CNT_WIDTH-1:0]                      cfg_count,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      rd_en,
    output logic [ADDR_WIDTH-1:0]                     rd_addr,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]         rd_data,
    output logic                                      pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0]         pe_data,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] pe_weights,
    input  logic [SUM_WIDTH*KERNEL_SIZE-1:0]          pe_result,
    input  logic                                      pe_result_done,
    output logic                                      out_valid,
    output logic [SUM_WIDTH*KERNEL_SIZE-1:0]          out_data,
    input  logic                                      out_ready
);
    localparam int ROW_W = DATA_WIDTH * KERNEL_SIZE;
    localparam int RES_W = SUM_WIDTH * KERNEL_SIZE;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CSW   = FCW + 1;
    localparam int KW    = $clog2(KERNEL_SIZE + 1);

    conv_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]       w_base_q, in_base_q;
    logic [CNT_WIDTH-1:0]        count_q;
    logic [KW-1:0]               w_iss_q, w_row_q;
    logic                        w_pend_q;
    logic [CNT_WIDTH-1:0]        iss_q, res_q;
    logic [FCW-1:0]              inflight_q;
    logic                        beat_pend_q;
    logic [ROW_W*KERNEL_SIZE-1:0] weights_q;

    logic                        fifo_valid;
    logic [FCW-1:0]              fifo_cnt;
    logic [RES_W-1:0]            fifo_head;
    logic                        push, pop;
    logic                        w_issue, run_issue, last_w_ret, drain_ok;
    logic [CSW-1:0]              credit_sum;

    always_comb begin
        w_issue    = (state_q == ST_LOAD_W) && (w_iss_q < KW'(KERNEL_SIZE));
        credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt};
        run_issue  = (state_q == ST_RUN) && (iss_q < count_q)
                     && (credit_sum < CSW'(FIFO_DEPTH));
        push       = pe_result_done && (state_q != ST_IDLE);
        pop        = fifo_valid && out_ready;
        last_w_ret = w_pend_q && (w_row_q == KW'(KERNEL_SIZE - 1));
        // Finish in the same cycle the final result leaves, so done follows the last pop directly.
        drain_ok   = (res_q == count_q)
                     && ((fifo_cnt == '0) || ((fifo_cnt == FCW'(1)) && pop && !push));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD_W;
            ST_LOAD_W: if (last_w_ret) state_d = (count_q == '0) ? ST_DONE : ST_RUN;
            ST_RUN:    if (run_issue && (iss_q + CNT_WIDTH'(1) == count_q)) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_ok) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            w_base_q    <= '0;
            in_base_q   <= '0;
            count_q     <= '0;
            w_iss_q     <= '0;
            w_row_q     <= '0;
            w_pend_q    <= 1'b0;
            iss_q       <= '0;
            res_q       <= '0;
            inflight_q  <= '0;
            beat_pend_q <= 1'b0;
            weights_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start) begin
                w_base_q   <= cfg_w_base;
                in_base_q  <= cfg_in_base;
                count_q    <= cfg_count;
                w_iss_q    <= '0;
                iss_q      <= '0;
                res_q      <= '0;
                inflight_q <= '0;
            end else begin
                if (w_issue)   w_iss_q <= w_iss_q + KW'(1);
                if (run_issue) iss_q   <= iss_q + CNT_WIDTH'(1);
                if (push)      res_q   <= res_q + CNT_WIDTH'(1);
                inflight_q <= inflight_q + FCW'(run_issue) - FCW'(push);
            end
            // Read data lags the strobe by one cycle; remember which row it belongs to.
            w_pend_q    <= w_issue;
            w_row_q     <= w_iss_q;
            beat_pend_q <= run_issue;
            if (w_pend_q) weights_q[int'(w_row_q) * ROW_W +: ROW_W] <= rd_data;
        end
    end

    always_comb begin
        rd_en   = w_issue || run_issue;
        rd_addr = '0;
        if (w_issue)        rd_addr = w_base_q + ADDR_WIDTH'(w_iss_q);
        else if (run_issue) rd_addr = in_base_q + ADDR_WIDTH'(iss_q);
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign pe_en      = beat_pend_q;
    assign pe_data    = beat_pend_q ? rd_data : '0;
    assign pe_weights = weights_q;
    assign out_valid  = fifo_valid;
    assign out_data   = fifo_head;

    result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (pe_result),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    // Results with no job in flight are dropped; they indicate a misbehaving PE array.
    a_no_idle_result: assert property (@(posedge clk) disable iff (rst)
        !((state_q == ST_IDLE) && pe_result_done));

endmodule
